pipeline_stall_controller: RTL

Central stall/flush sequencer for the 5-stage 8-bit pipeline. It merges three hazard sources into one consistent set of pipeline-register enables and bubble controls:
- load-use request from the hazard detection unit;
- taken-branch redirect from EX;
- data-memory wait handshake from MEM.

It also adds a watchdog that halts the core on a hung memory access. It sits between the hazard detection unit, the branch-resolve logic and the pipeline registers/PC.

---
 rtl/pipeline_stall_controller_pkg.sv | 13 +
 rtl/pipeline_stall_controller_if.sv | 46 ++++
 rtl/pipeline_stall_controller_sat_counter.sv | 20 ++
 rtl/pipeline_stall_controller.sv | 125 ++++++++++++
 4 files changed

// File: rtl/pipeline_stall_controller_pkg.sv
// rtl/pipeline_stall_controller_pkg.sv - shared state encoding and defaults for the stall controller
package pipe_ctl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  localparam int DEF_MEM_TIMEOUT = 15;
  localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// rtl/pipeline_stall_controller_if.sv - hazard inputs and pipeline control outputs (counters under STALL_CNT_EN)
interface pipeline_stall_controller_if
  import pipe_ctl_pkg::*;
`ifdef STALL_CNT_EN
  #(parameter int CNT_W = DEF_CNT_W)
`endif
  ();

  logic load_use;
  logic branch_taken;
  logic mem_req;
  logic mem_ack;
  logic pc_write;
  logic ifid_write;
  logic ifid_flush;
  logic idex_write;
  logic idex_nop;
  logic exmem_write;
  logic memwb_bubble;
  logic mem_timeout;
`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
`endif

  // Hazard sources / pipeline side
  modport master (
    output load_use, branch_taken, mem_req, mem_ack,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_nop,
           exmem_write, memwb_bubble, mem_timeout
`ifdef STALL_CNT_EN
    , input stall_cnt, flush_cnt
`endif
  );

  // Controller side
  modport slave (
    input  load_use, branch_taken, mem_req, mem_ack,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_nop,
           exmem_write, memwb_bubble, mem_timeout
`ifdef STALL_CNT_EN
    , output stall_cnt, flush_cnt
`endif
  );

endinterface

// File: rtl/pipeline_stall_controller_sat_counter.sv
// rtl/pipeline_stall_controller_sat_counter.sv - saturating incrementer used for performance counters
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, holding at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - stall/flush sequencer with memory watchdog (optional counters: STALL_CNT_EN)
module pipeline_stall_controller
  import pipe_ctl_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
`ifdef STALL_CNT_EN
  , parameter int CNT_W = DEF_CNT_W
`endif
) (
  input  logic                         clk,
  input  logic                         rst_n,
  pipeline_stall_controller_if.slave   bus
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_wait;
  logic              wait_last;

  logic pc_write;
  logic ifid_write;
  logic ifid_flush;
  logic idex_write;
  logic idex_nop;
  logic exmem_write;
  logic memwb_bubble;

  assign mem_wait  = bus.mem_req & ~bus.mem_ack;
  assign wait_last = (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Watchdog: counts consecutive frozen cycles, cleared whenever not waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if ((state != HALT) && mem_wait) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Next state and control outputs; priority is memory wait, branch, load-use
  always_comb begin
    state_nxt    = state;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_nop     = 1'b0;
    exmem_write  = 1'b1;
    memwb_bubble = 1'b0;
    case (state)
      RUN, MEM_WAIT: begin
        if (mem_wait) begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_write   = 1'b0;
          exmem_write  = 1'b0;
          memwb_bubble = 1'b1;
          state_nxt    = wait_last ? HALT : MEM_WAIT;
        end else begin
          state_nxt = RUN;
          if (bus.branch_taken) begin
            // ID holds a wrong-path instruction, so any load-use request is moot
            ifid_flush = 1'b1;
            idex_nop   = 1'b1;
          end else if (bus.load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_nop   = 1'b1;
          end
        end
      end
      HALT: begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        idex_write   = 1'b0;
        exmem_write  = 1'b0;
        memwb_bubble = 1'b1;
        state_nxt    = HALT;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  assign bus.pc_write     = pc_write;
  assign bus.ifid_write   = ifid_write;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_write   = idex_write;
  assign bus.idex_nop     = idex_nop;
  assign bus.exmem_write  = exmem_write;
  assign bus.memwb_bubble = memwb_bubble;
  assign bus.mem_timeout  = (state == HALT);

`ifdef STALL_CNT_EN
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~pc_write),
    .count (bus.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ifid_flush),
    .count (bus.flush_cnt)
  );
`endif

endmodule
